// File: rtl/vending_pkg.sv
// Shared types and constants for the coin-operated vending controller.
package vending_pkg;

    // Width used for credit, coin values and their sum (max 20 + 25 = 45).
    localparam int unsigned CREDIT_W = 6;

    localparam logic [CREDIT_W-1:0] PRICE  = 6'd25;
    localparam logic [CREDIT_W-1:0] COIN5  = 6'd5;
    localparam logic [CREDIT_W-1:0] COIN10 = 6'd10;
    localparam logic [CREDIT_W-1:0] COIN25 = 6'd25;

    // Each state encodes the credit currently held; credit never rests at or above PRICE.
    typedef enum logic [2:0] {
        S0  = 3'd0,
        S5  = 3'd1,
        S10 = 3'd2,
        S15 = 3'd3,
        S20 = 3'd4
    } state_t;

    // Value of the coin inserted this cycle; the highest coin wins and the rest are dropped.
    function automatic logic [CREDIT_W-1:0] coin_value(
        input logic five,
        input logic ten,
        input logic twenty_five
    );
        logic [CREDIT_W-1:0] value;
        value = '0;
        if (twenty_five) begin
            value = COIN25;
        end else if (ten) begin
            value = COIN10;
        end else if (five) begin
            value = COIN5;
        end
        return value;
    endfunction

    // Maps a sub-price credit amount back to its state; anything else lands in S0.
    function automatic state_t state_of_credit(input logic [CREDIT_W-1:0] credit);
        state_t st;
        unique case (credit)
            6'd0:    st = S0;
            6'd5:    st = S5;
            6'd10:   st = S10;
            6'd15:   st = S15;
            6'd20:   st = S20;
            default: st = S0;
        endcase
        return st;
    endfunction

endpackage

// File: rtl/mealy_machine.sv
// Mealy vending controller: accumulates 5/10/25 kurus coins and strobes theProduct
// in the same cycle the credit reaches the 25 kurus price. Overpayment is discarded.
module mealy_machine
    import vending_pkg::*;
(
    input  logic clock,
    input  logic reset,
    input  logic fiveKurus,
    input  logic tenKurus,
    input  logic twentyFiveKurus,
    output logic theProduct
);

    state_t              state_q;
    state_t              state_d;
    logic [CREDIT_W-1:0] credit;
    logic [CREDIT_W-1:0] coin;
    logic [CREDIT_W-1:0] sum;
    logic                state_legal;

    // State register with synchronous active-high reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= S0;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and Mealy output: vend on sum >= PRICE, otherwise store the new credit.
    always_comb begin
        state_d     = S0;
        theProduct  = 1'b0;
        credit      = '0;
        state_legal = 1'b1;
        coin        = coin_value(fiveKurus, tenKurus, twentyFiveKurus);

        case (state_q)
            S0:      credit = 6'd0;
            S5:      credit = 6'd5;
            S10:     credit = 6'd10;
            S15:     credit = 6'd15;
            S20:     credit = 6'd20;
            default: state_legal = 1'b0;
        endcase

        sum = credit + coin;

        if (reset || !state_legal) begin
            // Reset and unused encodings both return to S0 without vending.
            state_d    = S0;
            theProduct = 1'b0;
        end else if (sum >= PRICE) begin
            state_d    = S0;
            theProduct = 1'b1;
        end else begin
            state_d    = state_of_credit(sum);
            theProduct = 1'b0;
        end
    end

endmodule

// File: tb/tb_mealy_machine.sv
// Directed bench for mealy_machine: checks the vend strobe before each edge and the
// stored credit state after each edge against hand-computed values.
module tb_mealy_machine;
    import vending_pkg::*;

    logic clock = 1'b0;
    logic reset;
    logic fiveKurus;
    logic tenKurus;
    logic twentyFiveKurus;
    logic theProduct;

    int checks   = 0;
    int failures = 0;

    mealy_machine dut (
        .clock           (clock),
        .reset           (reset),
        .fiveKurus       (fiveKurus),
        .tenKurus        (tenKurus),
        .twentyFiveKurus (twentyFiveKurus),
        .theProduct      (theProduct)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [7:0] observed, input logic [7:0] expected);
        checks++;
        if (observed !== expected) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, observed, expected);
        end
    endtask

    // One cycle: apply inputs, check the Mealy output mid-cycle, then the state after the edge.
    task automatic step(
        input string  tag,
        input logic   rst,
        input logic   f,
        input logic   t,
        input logic   tf,
        input logic   exp_prod,
        input state_t exp_state
    );
        reset           = rst;
        fiveKurus       = f;
        tenKurus        = t;
        twentyFiveKurus = tf;
        @(negedge clock);
        check({tag, ".prod"}, {7'd0, theProduct}, {7'd0, exp_prod});
        @(posedge clock);
        #1;
        check({tag, ".state"}, {5'd0, dut.state_q}, {5'd0, exp_state});
    endtask

    initial begin
        reset           = 1'b1;
        fiveKurus       = 1'b0;
        tenKurus        = 1'b1;
        twentyFiveKurus = 1'b0;

        // Reset held two cycles with a coin present: no vend, S0.
        step("rst0", 1, 0, 1, 0, 0, S0);
        step("rst1", 1, 0, 1, 0, 0, S0);

        // ten, five, five, ten, idle: 30 vends, 5 overpay dropped.
        step("a_ten",   0, 0, 1, 0, 0, S10);
        step("a_five",  0, 1, 0, 0, 0, S15);
        step("a_five2", 0, 1, 0, 0, 0, S20);
        step("a_ten2",  0, 0, 1, 0, 1, S0);
        step("a_idle",  0, 0, 0, 0, 0, S0);

        // Five tens from S0, then idle holds S20.
        step("b_ten1", 0, 0, 1, 0, 0, S10);
        step("b_ten2", 0, 0, 1, 0, 0, S20);
        step("b_ten3", 0, 0, 1, 0, 1, S0);
        step("b_ten4", 0, 0, 1, 0, 0, S10);
        step("b_ten5", 0, 0, 1, 0, 0, S20);
        step("b_idle", 0, 0, 0, 0, 0, S20);

        // Clear, then a single 25 from S0 and from S15.
        step("c_rst",   1, 0, 0, 0, 0, S0);
        step("c_25s0",  0, 0, 0, 1, 1, S0);
        step("c_ten",   0, 0, 1, 0, 0, S10);
        step("c_five",  0, 1, 0, 0, 0, S15);
        step("c_25s15", 0, 0, 0, 1, 1, S0);

        // Priority: all three from S5 counts as 25; ten+five from S0 counts as 10.
        step("d_five", 0, 1, 0, 0, 0, S5);
        step("d_all",  0, 1, 1, 1, 1, S0);
        step("d_tf",   0, 1, 1, 0, 0, S10);

        // Reset from S20 with a five present: no vend, back to S0.
        step("e_ten",  0, 0, 1, 0, 0, S20);
        step("e_rst",  1, 1, 0, 0, 0, S0);
        step("e_idle", 0, 0, 0, 0, 0, S0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
